// File: rtl/shiftreg4_ctrl_pkg.sv
// Shared types and constants for the two-source 4-bit serial shifter.
package shiftreg4_ctrl_pkg;

    localparam int WORD_BITS = 4;
    localparam int CNT_BITS  = 2;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

endpackage

// File: rtl/shiftreg4_ctrl_if.sv
// Requester, stall and serial-output bundle of shiftreg4_ctrl.
interface shiftreg4_ctrl_if;
    import shiftreg4_ctrl_pkg::*;

    logic                 req_a;
    logic [WORD_BITS-1:0] data_a;
    logic                 gnt_a;
    logic                 req_b;
    logic [WORD_BITS-1:0] data_b;
    logic                 gnt_b;
    logic                 stall;
    logic                 sout;
    logic                 svalid;
    logic                 sfirst;
    logic                 done;
    logic                 done_src;
    logic                 busy;

    modport master (
        output req_a, data_a, req_b, data_b, stall,
        input  gnt_a, gnt_b, sout, svalid, sfirst, done, done_src, busy
    );

    modport slave (
        input  req_a, data_a, req_b, data_b, stall,
        output gnt_a, gnt_b, sout, svalid, sfirst, done, done_src, busy
    );

endinterface

// File: rtl/shiftreg4_ctrl_core.sv
// Word register with parallel load and zero-fill serial shift in either direction.
module shift4_core
    import shiftreg4_ctrl_pkg::*;
#(
    parameter int MSB_FIRST = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 shift_en,
    input  logic [WORD_BITS-1:0] din,
    output logic                 sbit
);

    logic [WORD_BITS-1:0] word_r;

    // Load outranks shift so a fresh grant always starts from the captured word
    always_ff @(posedge clk) begin
        if (reset) begin
            word_r <= {WORD_BITS{1'b0}};
        end else if (load) begin
            word_r <= din;
        end else if (shift_en) begin
            if (MSB_FIRST != 0) begin
                word_r <= {word_r[WORD_BITS-2:0], 1'b0};
            end else begin
                word_r <= {1'b0, word_r[WORD_BITS-1:1]};
            end
        end else begin
            word_r <= word_r;
        end
    end

    assign sbit = (MSB_FIRST != 0) ? word_r[WORD_BITS-1] : word_r[0];

endmodule

// File: rtl/shiftreg4_ctrl.sv
// Round-robin arbiter and sequencer that shares one 4-bit shift register
// between two word sources and streams each word out serially with stall.
module shiftreg4_ctrl
    import shiftreg4_ctrl_pkg::*;
#(
    parameter int MSB_FIRST = 0,
    parameter int IDLE_GAP  = 1
) (
    input  logic             clk,
    input  logic             reset,
    shiftreg4_ctrl_if.slave  bus
);

    localparam logic [CNT_BITS-1:0] GAP_LAST = CNT_BITS'(IDLE_GAP - 1);

    state_e               state_r;
    state_e               state_nxt_s;
    logic [CNT_BITS-1:0]  cnt_r;
    logic [CNT_BITS-1:0]  gap_r;
    logic                 ptr_r;
    logic                 src_r;
    logic                 done_r;
    logic                 done_src_r;
    logic                 win_s;
    logic                 grant_s;
    logic                 accept_s;
    logic                 last_s;
    logic                 sbit_s;
    logic [WORD_BITS-1:0] din_s;

    // Favoured requester wins when it asks, otherwise the other one does
    always_comb begin
        win_s = SRC_A;
        if (ptr_r == SRC_A) begin
            win_s = bus.req_a ? SRC_A : SRC_B;
        end else begin
            win_s = bus.req_b ? SRC_B : SRC_A;
        end
    end

    assign grant_s  = (state_r == IDLE) & (bus.req_a | bus.req_b) & ~reset;
    assign accept_s = (state_r == SHIFT) & ~bus.stall;
    assign last_s   = accept_s & (cnt_r == 2'd3);
    assign din_s    = (win_s == SRC_A) ? bus.data_a : bus.data_b;

    shift4_core #(
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (grant_s),
        .shift_en (accept_s),
        .din      (din_s),
        .sbit     (sbit_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_s) state_nxt_s = SHIFT;
                else         state_nxt_s = IDLE;
            end
            SHIFT: begin
                if (last_s) state_nxt_s = (IDLE_GAP == 0) ? IDLE : GAP;
                else        state_nxt_s = SHIFT;
            end
            GAP: begin
                if (gap_r == GAP_LAST) state_nxt_s = IDLE;
                else                   state_nxt_s = GAP;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Pointer, source, bit/gap counters and the registered completion pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r      <= 2'd0;
            gap_r      <= 2'd0;
            ptr_r      <= SRC_A;
            src_r      <= SRC_A;
            done_r     <= 1'b0;
            done_src_r <= 1'b0;
        end else begin
            done_r <= last_s;
            if (last_s) begin
                done_src_r <= src_r;
            end
            if (grant_s) begin
                src_r <= win_s;
                ptr_r <= ~win_s;
                cnt_r <= 2'd0;
            end else if (accept_s) begin
                cnt_r <= cnt_r + 2'd1;
            end
            if (state_r == GAP) begin
                gap_r <= gap_r + 2'd1;
            end else begin
                gap_r <= 2'd0;
            end
        end
    end

    // Output decode; serial outputs depend on registered state only
    always_comb begin
        bus.gnt_a    = grant_s & (win_s == SRC_A);
        bus.gnt_b    = grant_s & (win_s == SRC_B);
        bus.svalid   = (state_r == SHIFT);
        bus.sout     = (state_r == SHIFT) & sbit_s;
        bus.sfirst   = (state_r == SHIFT) & (cnt_r == 2'd0);
        bus.busy     = (state_r != IDLE);
        bus.done     = done_r;
        bus.done_src = done_src_r;
    end

endmodule

// File: tb/tb_shiftreg4_ctrl.sv
// Directed bench for shiftreg4_ctrl: three instances cover LSB/MSB order and
// gap 1/0; every task drives stimulus and compares against hand-derived values.
module tb_shiftreg4_ctrl;
    import shiftreg4_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    shiftreg4_ctrl_if i0 ();
    shiftreg4_ctrl_if i1 ();
    shiftreg4_ctrl_if i2 ();

    shiftreg4_ctrl #(.MSB_FIRST(0), .IDLE_GAP(1)) dut0 (.clk(clk), .reset(reset), .bus(i0.slave));
    shiftreg4_ctrl #(.MSB_FIRST(1), .IDLE_GAP(1)) dut1 (.clk(clk), .reset(reset), .bus(i1.slave));
    shiftreg4_ctrl #(.MSB_FIRST(0), .IDLE_GAP(0)) dut2 (.clk(clk), .reset(reset), .bus(i2.slave));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic init_inputs();
        i0.req_a = 1'b0; i0.req_b = 1'b0; i0.data_a = 4'b0000; i0.data_b = 4'b0000; i0.stall = 1'b0;
        i1.req_a = 1'b0; i1.req_b = 1'b0; i1.data_a = 4'b0000; i1.data_b = 4'b0000; i1.stall = 1'b0;
        i2.req_a = 1'b0; i2.req_b = 1'b0; i2.data_a = 4'b0000; i2.data_b = 4'b0000; i2.stall = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        i0.req_a  = 1'b1;
        i0.data_a = 4'b1010;
        #1;
        checks++;
        if ({i0.gnt_a, i0.gnt_b} !== 2'b00) begin
            errors++; $display("FAIL reset_no_grant got %b exp 00", {i0.gnt_a, i0.gnt_b});
        end
        checks++;
        if ({i0.sout, i0.svalid, i0.sfirst, i0.done, i0.done_src, i0.busy} !== 6'b000000) begin
            errors++; $display("FAIL reset_outputs_dut0 got %b exp 000000",
                {i0.sout, i0.svalid, i0.sfirst, i0.done, i0.done_src, i0.busy});
        end
        checks++;
        if ({i1.svalid, i1.busy, i2.svalid, i2.busy} !== 4'b0000) begin
            errors++; $display("FAIL reset_outputs_dut12 got %b exp 0000",
                {i1.svalid, i1.busy, i2.svalid, i2.busy});
        end
        i0.req_a = 1'b0;
        step();
        reset = 1'b0;
        step();
        #1;
        checks++;
        if ({i0.gnt_a, i0.gnt_b, i0.sout, i0.svalid, i0.sfirst, i0.done, i0.done_src, i0.busy} !== 8'b00000000) begin
            errors++; $display("FAIL post_reset_idle got %b exp 00000000",
                {i0.gnt_a, i0.gnt_b, i0.sout, i0.svalid, i0.sfirst, i0.done, i0.done_src, i0.busy});
        end
    endtask

    task automatic test_basic();
        logic [3:0] bits;
        logic [2:0] exp_v;
        bits = 4'b1011;
        do_reset();
        i0.req_a  = 1'b1;
        i0.data_a = 4'b1011;
        #1;
        checks++;
        if ({i0.gnt_a, i0.gnt_b} !== 2'b10) begin
            errors++; $display("FAIL basic_grant got %b exp 10", {i0.gnt_a, i0.gnt_b});
        end
        step();
        i0.req_a  = 1'b0;
        i0.data_a = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_v = {1'b1, bits[k], (k == 0)};
            checks++;
            if ({i0.svalid, i0.sout, i0.sfirst} !== exp_v) begin
                errors++; $display("FAIL basic_bit%0d got %b exp %b", k, {i0.svalid, i0.sout, i0.sfirst}, exp_v);
            end
            step();
        end
        #1;
        checks++;
        if ({i0.done, i0.done_src, i0.svalid, i0.busy} !== 4'b1001) begin
            errors++; $display("FAIL basic_done got %b exp 1001", {i0.done, i0.done_src, i0.svalid, i0.busy});
        end
        step();
        #1;
        checks++;
        if ({i0.done, i0.busy} !== 2'b00) begin
            errors++; $display("FAIL basic_after_gap got %b exp 00", {i0.done, i0.busy});
        end
    endtask

    task automatic test_alternate();
        logic exp_a;
        logic exp_b;
        logic exp_d;
        do_reset();
        i0.req_a  = 1'b1;
        i0.req_b  = 1'b1;
        i0.data_a = 4'b0110;
        i0.data_b = 4'b1001;
        for (int c = 0; c < 24; c++) begin
            #1;
            exp_a = ((c % 6) == 0) && (((c / 6) % 2) == 0);
            exp_b = ((c % 6) == 0) && (((c / 6) % 2) == 1);
            exp_d = ((c % 6) == 5);
            checks++;
            if ({i0.gnt_a, i0.gnt_b, i0.done} !== {exp_a, exp_b, exp_d}) begin
                errors++; $display("FAIL alt_cycle%0d gnt_a/gnt_b/done got %b exp %b",
                    c, {i0.gnt_a, i0.gnt_b, i0.done}, {exp_a, exp_b, exp_d});
            end
            if (exp_d) begin
                checks++;
                if (i0.done_src !== (((c / 6) % 2) == 1)) begin
                    errors++; $display("FAIL alt_done_src cycle%0d got %b exp %b",
                        c, i0.done_src, (((c / 6) % 2) == 1));
                end
            end
            step();
        end
        i0.req_a = 1'b0;
        i0.req_b = 1'b0;
    endtask

    task automatic test_stall();
        logic [6:0] seq;
        logic [3:0] exp_v;
        seq = 7'b0100001;
        do_reset();
        i0.req_a  = 1'b1;
        i0.data_a = 4'b0101;
        #1;
        checks++;
        if (i0.gnt_a !== 1'b1) begin
            errors++; $display("FAIL stall_grant got %b exp 1", i0.gnt_a);
        end
        step();
        i0.req_a = 1'b0;
        for (int j = 0; j < 7; j++) begin
            i0.stall = (j >= 1) && (j <= 3);
            #1;
            exp_v = {1'b1, seq[j], (j == 0), 1'b0};
            checks++;
            if ({i0.svalid, i0.sout, i0.sfirst, i0.done} !== exp_v) begin
                errors++; $display("FAIL stall_cycle%0d got %b exp %b",
                    j + 1, {i0.svalid, i0.sout, i0.sfirst, i0.done}, exp_v);
            end
            step();
        end
        i0.stall = 1'b0;
        #1;
        checks++;
        if ({i0.done, i0.done_src} !== 2'b10) begin
            errors++; $display("FAIL stall_done got %b exp 10", {i0.done, i0.done_src});
        end
    endtask

    task automatic test_msb_first();
        logic [3:0] bits;
        logic [2:0] exp_v;
        bits = 4'b1000;
        do_reset();
        i1.req_b  = 1'b1;
        i1.data_b = 4'b0001;
        #1;
        checks++;
        if ({i1.gnt_a, i1.gnt_b} !== 2'b01) begin
            errors++; $display("FAIL msb_grant got %b exp 01", {i1.gnt_a, i1.gnt_b});
        end
        step();
        i1.req_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_v = {1'b1, bits[k], (k == 0)};
            checks++;
            if ({i1.svalid, i1.sout, i1.sfirst} !== exp_v) begin
                errors++; $display("FAIL msb_bit%0d got %b exp %b", k, {i1.svalid, i1.sout, i1.sfirst}, exp_v);
            end
            step();
        end
        #1;
        checks++;
        if ({i1.done, i1.done_src} !== 2'b11) begin
            errors++; $display("FAIL msb_done got %b exp 11", {i1.done, i1.done_src});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        i0.req_a  = 1'b1;
        i0.data_a = 4'b1111;
        step();
        i0.req_a = 1'b0;
        step();
        step();
        #1;
        checks++;
        if ({i0.svalid, i0.sout} !== 2'b11) begin
            errors++; $display("FAIL midrst_third_bit got %b exp 11", {i0.svalid, i0.sout});
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++;
        if ({i0.svalid, i0.busy, i0.sout, i0.done} !== 4'b0000) begin
            errors++; $display("FAIL midrst_abort got %b exp 0000", {i0.svalid, i0.busy, i0.sout, i0.done});
        end
        for (int c = 0; c < 4; c++) begin
            step();
            #1;
            checks++;
            if ({i0.done, i0.busy} !== 2'b00) begin
                errors++; $display("FAIL midrst_no_done cycle%0d got %b exp 00", c, {i0.done, i0.busy});
            end
        end
        i0.req_a  = 1'b1;
        i0.req_b  = 1'b1;
        i0.data_b = 4'b0110;
        #1;
        checks++;
        if ({i0.gnt_a, i0.gnt_b} !== 2'b10) begin
            errors++; $display("FAIL midrst_ptr got %b exp 10", {i0.gnt_a, i0.gnt_b});
        end
        step();
        i0.req_a = 1'b0;
        i0.req_b = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] bits;
        logic       exp_g;
        bits = 4'b0011;
        do_reset();
        i2.req_b  = 1'b1;
        i2.data_b = 4'b0011;
        for (int c = 0; c < 11; c++) begin
            #1;
            exp_g = ((c % 5) == 0);
            checks++;
            if ({i2.gnt_a, i2.gnt_b} !== {1'b0, exp_g}) begin
                errors++; $display("FAIL b2b_grant cycle%0d got %b exp %b", c, {i2.gnt_a, i2.gnt_b}, {1'b0, exp_g});
            end
            if ((c % 5) != 0) begin
                checks++;
                if ({i2.svalid, i2.sout, i2.done} !== {1'b1, bits[(c % 5) - 1], 1'b0}) begin
                    errors++; $display("FAIL b2b_bit cycle%0d got %b exp %b",
                        c, {i2.svalid, i2.sout, i2.done}, {1'b1, bits[(c % 5) - 1], 1'b0});
                end
            end else if (c > 0) begin
                checks++;
                if ({i2.done, i2.done_src, i2.svalid} !== 3'b110) begin
                    errors++; $display("FAIL b2b_done cycle%0d got %b exp 110", c, {i2.done, i2.done_src, i2.svalid});
                end
            end
            step();
        end
        i2.req_b = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        init_inputs();
        test_reset();
        test_basic();
        test_alternate();
        test_stall();
        test_msb_first();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
